// File: rtl/bcd_timer_n.sv
// -----------------------------------------------------------------------------
// bcd_timer_n -- N-digit BCD up/down timer (SS, MM, HH... digit pairs)
//
// Counts between LOW_LIMIT and HIGH_LIMIT at a rate set by an internal tick
// prescaler. Runtime speed select, minute-digit ADD/SUBTRACT adjust with
// saturation at the limits, and a sticky error state that shows an error code
// and a fixed display pattern.
//
// Optional feature macro: BCD_TIMER_LAP_EN (lap capture and lap display).
//
// Parameters:
//   DIGITS      number of BCD digits (even, >= 2); digit 0 is least significant
//   TICK_DIV    clk_in cycles per count step at normal speed (>= 4, multiple of 4)
//   LOW_LIMIT   BCD lower bound
//   HIGH_LIMIT  BCD upper bound
//   ERR_PATTERN nibble repeated across D_Q while in the error state
//
// Ports:
//   clk_in      system clock
//   RESET       synchronous, active-high reset
//   START       level: 1 = run, 0 = pause
//   REVERSE     level: 0 = count up, 1 = count down
//   SPEED_UP    level: step every TICK_DIV/4 cycles
//   SPEED_DOWN  level: step every TICK_DIV*4 cycles
//   ADD         pulse: +1 on digit 2 (minutes units)
//   SUBTRACT    pulse: -1 on digit 2
//   LAP         pulse: capture count into LAP_Q while running (lap build only)
//   LAP_SHOW    level: show LAP_Q on D_Q (lap build only)
//   LAP_Q       captured lap value (lap build only)
//   D_Q         display value (BCD count, or the error pattern)
//   RUNNING     state is RUN
//   DONE        target limit reached
//   ERR_CODE    00 none, 01 reverse-while-running, 10 speed conflict
// -----------------------------------------------------------------------------
module bcd_timer_n #(
    parameter int                  DIGITS      = 4,
    parameter int                  TICK_DIV    = 50000000,
    parameter logic [4*DIGITS-1:0] LOW_LIMIT   = 16'h1020,
    parameter logic [4*DIGITS-1:0] HIGH_LIMIT  = 16'h4930,
    parameter logic [3:0]          ERR_PATTERN = 4'h5
) (
    input  logic                clk_in,
    input  logic                RESET,
    input  logic                START,
    input  logic                REVERSE,
    input  logic                SPEED_UP,
    input  logic                SPEED_DOWN,
    input  logic                ADD,
    input  logic                SUBTRACT,
`ifdef BCD_TIMER_LAP_EN
    input  logic                LAP,
    input  logic                LAP_SHOW,
    output logic [4*DIGITS-1:0] LAP_Q,
`endif
    output logic [4*DIGITS-1:0] D_Q,
    output logic                RUNNING,
    output logic                DONE,
    output logic [1:0]          ERR_CODE
);

    localparam int W        = 4 * DIGITS;
    localparam int DIV_SLOW = TICK_DIV * 4;
    localparam int PW       = $clog2(DIV_SLOW);

    localparam logic [PW-1:0] NORM_M1 = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] FAST_M1 = PW'(TICK_DIV / 4 - 1);
    localparam logic [PW-1:0] SLOW_M1 = PW'(DIV_SLOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal value of a digit: seconds/minutes tens digits wrap at 5,
    // everything else (and the top digit) wraps at 9.
    function automatic logic [3:0] digit_max(input int idx);
        if ((idx % 2 == 0) || (idx == DIGITS - 1)) return 4'd9;
        return 4'd5;
    endfunction

    // +1 starting at digit 'first', rippling upward. MSB of the result is the
    // carry out of the top digit.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v, input int first);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (i >= first && carry) begin
                if (d >= digit_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

    // -1 starting at digit 'first', rippling upward. MSB is the borrow out.
    function automatic logic [W:0] bcd_dec(input logic [W-1:0] v, input int first);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (i >= first && borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return {borrow, r};
    endfunction

    state_t        state, state_n;
    logic [W-1:0]  count, count_n;
    logic [1:0]    err_code, err_n;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] div_m1;
    logic          rev_q;
    logic          tick;
    logic          run_en;

    logic [W:0]    step_inc, step_dec, adj_inc, adj_dec;
    logic [W-1:0]  step_val, add_val, sub_val, adj_val, target;

    assign step_inc = bcd_inc(count, 0);
    assign step_dec = bcd_dec(count, 0);
    assign adj_inc  = bcd_inc(count, 2);
    assign adj_dec  = bcd_dec(count, 2);

    // Run steps clamp at the limit so the count can never pass it.
    assign step_val = REVERSE
        ? ((step_dec[W] || step_dec[W-1:0] <= LOW_LIMIT)  ? LOW_LIMIT  : step_dec[W-1:0])
        : ((step_inc[W] || step_inc[W-1:0] >= HIGH_LIMIT) ? HIGH_LIMIT : step_inc[W-1:0]);

    // Minute adjust saturates: overshoot loads the limit itself.
    assign add_val = (adj_inc[W] || adj_inc[W-1:0] > HIGH_LIMIT) ? HIGH_LIMIT : adj_inc[W-1:0];
    assign sub_val = (adj_dec[W] || adj_dec[W-1:0] < LOW_LIMIT)  ? LOW_LIMIT  : adj_dec[W-1:0];

    // Simultaneous ADD and SUBTRACT cancel out.
    assign adj_val = (ADD && !SUBTRACT) ? add_val :
                     (SUBTRACT && !ADD) ? sub_val : count;

    assign target = REVERSE ? LOW_LIMIT : HIGH_LIMIT;

    always_comb begin
        div_m1 = NORM_M1;
        if (SPEED_UP)        div_m1 = FAST_M1;
        else if (SPEED_DOWN) div_m1 = SLOW_M1;
    end

    // Greater-or-equal so a switch to a faster speed mid-interval still fires.
    assign tick = (prescaler >= div_m1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n = state;
        count_n = count;
        err_n   = err_code;
        run_en  = 1'b0;

        if (SPEED_UP && SPEED_DOWN && state != S_ERR) begin
            // Speed conflict wins over a same-cycle reverse error.
            state_n = S_ERR;
            err_n   = 2'b10;
        end else begin
            case (state)
                S_IDLE, S_PAUSE: begin
                    count_n = adj_val;
                    if (adj_val != count && adj_val == target) state_n = S_DONE;
                    else if (START)                            state_n = S_RUN;
                end
                S_RUN: begin
                    if (REVERSE != rev_q) begin
                        state_n = S_ERR;
                        err_n   = 2'b01;
                    end else if (!START) begin
                        state_n = S_PAUSE;
                    end else if (count == target) begin
                        state_n = S_DONE;
                    end else begin
                        run_en = 1'b1;
                        if (tick) count_n = step_val;
                    end
                end
                S_DONE: begin
                    // Only an adjust that actually moves the count releases DONE.
                    count_n = adj_val;
                    if (adj_val != count) state_n = S_PAUSE;
                end
                S_ERR: begin
                    state_n = S_ERR;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        rev_q <= REVERSE;
        if (RESET) begin
            state     <= S_IDLE;
            count     <= REVERSE ? HIGH_LIMIT : LOW_LIMIT;
            prescaler <= '0;
            err_code  <= 2'b00;
            RUNNING   <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            err_code <= err_n;
            RUNNING  <= (state_n == S_RUN);
            DONE     <= (state_n == S_DONE);
            // Outside RUN the prescaler simply holds its value.
            if (run_en) prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    assign ERR_CODE = err_code;

`ifdef BCD_TIMER_LAP_EN
    logic [W-1:0] lap_q;

    always_ff @(posedge clk_in) begin
        if (RESET)                       lap_q <= '0;
        else if (state == S_RUN && LAP)  lap_q <= count;
    end

    assign LAP_Q = lap_q;
`endif

    // NOTE: the display register is a pure pipeline stage of count/state and
    // is deliberately left out of reset; it shows the reset value one cycle
    // after RESET is applied.
    always_ff @(posedge clk_in) begin
        if (state == S_ERR) D_Q <= {DIGITS{ERR_PATTERN}};
`ifdef BCD_TIMER_LAP_EN
        else if (LAP_SHOW)  D_Q <= lap_q;
`endif
        else                D_Q <= count;
    end

endmodule

// File: tb/tb_bcd_timer_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_n -- self-checking bench for bcd_timer_n (DIGITS=4, TICK_DIV=4)
//
// Table rows of {inputs, expected outputs} go through an expectation queue,
// plus hand-written sequences for full up/down runs, pause/adjust saturation
// and (when BCD_TIMER_LAP_EN is defined) lap capture.
// -----------------------------------------------------------------------------
module tb_bcd_timer_n;

    logic        clk_in = 1'b0;
    logic        RESET = 1'b0, START = 1'b0, REVERSE = 1'b0;
    logic        SPEED_UP = 1'b0, SPEED_DOWN = 1'b0, ADD = 1'b0, SUBTRACT = 1'b0;
    logic [15:0] D_Q;
    logic        RUNNING, DONE;
    logic [1:0]  ERR_CODE;
`ifdef BCD_TIMER_LAP_EN
    logic        LAP = 1'b0, LAP_SHOW = 1'b0;
    logic [15:0] LAP_Q;
`endif

    bcd_timer_n #(
        .DIGITS     (4),
        .TICK_DIV   (4),
        .LOW_LIMIT  (16'h1020),
        .HIGH_LIMIT (16'h4930),
        .ERR_PATTERN(4'h5)
    ) dut (
        .clk_in    (clk_in),
        .RESET     (RESET),
        .START     (START),
        .REVERSE   (REVERSE),
        .SPEED_UP  (SPEED_UP),
        .SPEED_DOWN(SPEED_DOWN),
        .ADD       (ADD),
        .SUBTRACT  (SUBTRACT),
`ifdef BCD_TIMER_LAP_EN
        .LAP       (LAP),
        .LAP_SHOW  (LAP_SHOW),
        .LAP_Q     (LAP_Q),
`endif
        .D_Q       (D_Q),
        .RUNNING   (RUNNING),
        .DONE      (DONE),
        .ERR_CODE  (ERR_CODE)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        rst, start, rev, su, sd, add, sub;
        logic        chk_dq;
        logic [15:0] dq;
        logic        run, done;
        logic [1:0]  err;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [0:NV-1];
    vec_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic vec_t mk(input logic rst, start, rev, su, sd, add, sub,
                                input logic chk, input logic [15:0] dq,
                                input logic run, done, input logic [1:0] err);
        vec_t v;
        v.rst = rst; v.start = start; v.rev = rev; v.su = su; v.sd = sd;
        v.add = add; v.sub = sub; v.chk_dq = chk; v.dq = dq;
        v.run = run; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic apply_rows(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i <= hi; i++) begin
            RESET = tbl[i].rst; START = tbl[i].start; REVERSE = tbl[i].rev;
            SPEED_UP = tbl[i].su; SPEED_DOWN = tbl[i].sd;
            ADD = tbl[i].add; SUBTRACT = tbl[i].sub;
            exp_q.push_back(tbl[i]);
            tick();
            e = exp_q.pop_front();
            if (e.chk_dq) check($sformatf("row%0d_dq", i), 32'(D_Q), 32'(e.dq));
            check($sformatf("row%0d_running", i), 32'(RUNNING), 32'(e.run));
            check($sformatf("row%0d_done", i), 32'(DONE), 32'(e.done));
            check($sformatf("row%0d_err", i), 32'(ERR_CODE), 32'(e.err));
        end
    endtask

    // MM:SS <-> seconds, used to derive every expected step value.
    function automatic int to_sec(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] from_sec(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic drive_idle();
        RESET = 1'b0; START = 1'b0; SPEED_UP = 1'b0; SPEED_DOWN = 1'b0;
        ADD = 1'b0; SUBTRACT = 1'b0;
    endtask

    initial begin
        logic [15:0] prev;
        int          gap;
        logic        found;

        //             rst st rv su sd ad sb  chk dq        run dn err
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 2'b00);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h1020, 0, 0, 2'b00);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1021, 1, 0, 2'b00);
        // reverse while running -> error 01
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 2'b00);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h1020, 0, 0, 2'b00);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[12] = mk(0, 1, 1, 0, 0, 0, 0,  1, 16'h1020, 0, 0, 2'b01);
        tbl[13] = mk(0, 1, 1, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b01);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b01);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b01);
        tbl[16] = mk(1, 0, 1, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b00);
        tbl[17] = mk(1, 0, 1, 0, 0, 0, 0,  1, 16'h4930, 0, 0, 2'b00);
        tbl[18] = mk(0, 0, 1, 0, 0, 0, 0,  1, 16'h4930, 0, 0, 2'b00);
        // fast speed counting down, then speed conflict -> error 10
        tbl[19] = mk(0, 1, 1, 1, 0, 0, 0,  1, 16'h4930, 1, 0, 2'b00);
        tbl[20] = mk(0, 1, 1, 1, 0, 0, 0,  1, 16'h4930, 1, 0, 2'b00);
        tbl[21] = mk(0, 1, 1, 1, 0, 0, 0,  1, 16'h4929, 1, 0, 2'b00);
        tbl[22] = mk(0, 1, 1, 1, 0, 0, 0,  1, 16'h4928, 1, 0, 2'b00);
        tbl[23] = mk(0, 1, 1, 1, 1, 0, 0,  1, 16'h4927, 0, 0, 2'b10);
        tbl[24] = mk(0, 1, 1, 1, 1, 0, 0,  1, 16'h5555, 0, 0, 2'b10);
        // speed conflict beats a same-cycle reverse error; conflict in IDLE
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b00);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h1020, 0, 0, 2'b00);
        tbl[27] = mk(0, 1, 0, 0, 0, 0, 0,  1, 16'h1020, 1, 0, 2'b00);
        tbl[28] = mk(0, 1, 1, 1, 1, 0, 0,  1, 16'h1020, 0, 0, 2'b10);
        tbl[29] = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 2'b00);
        tbl[30] = mk(1, 0, 0, 0, 0, 0, 0,  1, 16'h1020, 0, 0, 2'b00);
        tbl[31] = mk(0, 0, 0, 1, 1, 0, 0,  1, 16'h1020, 0, 0, 2'b10);
        tbl[32] = mk(1, 0, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 2'b00);

        // ---- reset and first step ----
        apply_rows(0, 7);

        // ---- full up run to HIGH_LIMIT ----
        prev  = 16'h1021;
        gap   = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            tick();
            gap++;
            if (D_Q != prev) begin
                check("up_step_value", 32'(D_Q), 32'(from_sec(to_sec(prev) + 1)));
                check("up_step_period", 32'(gap), 32'd4);
                prev = D_Q;
                gap  = 0;
            end
            if (DONE) begin
                found = 1'b1;
                break;
            end
        end
        check("up_done_reached", 32'(found), 32'd1);
        check("up_done_dq", 32'(D_Q), 32'h4930);
        check("up_done_running", 32'(RUNNING), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("up_done_hold_dq", 32'(D_Q), 32'h4930);
        check("up_done_hold_flag", 32'(DONE), 32'd1);

        // ---- full down run to LOW_LIMIT ----
        drive_idle();
        RESET = 1'b1; REVERSE = 1'b1;
        tick(); tick();
        check("down_reset_dq", 32'(D_Q), 32'h4930);
        RESET = 1'b0; START = 1'b1;
        prev  = 16'h4930;
        found = 1'b0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            tick();
            if (D_Q != prev) begin
                check("down_step_value", 32'(D_Q), 32'(from_sec(to_sec(prev) - 1)));
                if (prev == 16'h4900) check("down_borrow_4900", 32'(D_Q), 32'h4859);
                prev = D_Q;
            end
            if (DONE) begin
                found = 1'b1;
                break;
            end
        end
        check("down_done_reached", 32'(found), 32'd1);
        check("down_done_dq", 32'(D_Q), 32'h1020);

        // ---- pause at 10:59, minute adjust and saturation ----
        drive_idle();
        RESET = 1'b1; REVERSE = 1'b0;
        tick(); tick();
        RESET = 1'b0; START = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            tick();
            if (D_Q == 16'h1059) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_1059", 32'(found), 32'd1);
        START = 1'b0;
        tick();
        check("pause_running", 32'(RUNNING), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("pause_hold_dq", 32'(D_Q), 32'h1059);
        ADD = 1'b1; tick(); ADD = 1'b0; tick();
        check("add_1159", 32'(D_Q), 32'h1159);
        for (int i = 0; i < 40; i++) begin
            ADD = 1'b1; tick(); ADD = 1'b0; tick();
        end
        check("add_sat_dq", 32'(D_Q), 32'h4930);
        check("add_sat_done", 32'(DONE), 32'd1);
        SUBTRACT = 1'b1; tick(); SUBTRACT = 1'b0; tick();
        check("sub_4830_dq", 32'(D_Q), 32'h4830);
        check("sub_4830_done", 32'(DONE), 32'd0);
        check("sub_4830_running", 32'(RUNNING), 32'd0);
        ADD = 1'b1; SUBTRACT = 1'b1; tick();
        ADD = 1'b0; SUBTRACT = 1'b0; tick();
        check("add_sub_cancel", 32'(D_Q), 32'h4830);
        RESET = 1'b1; ADD = 1'b1; tick();
        ADD = 1'b0; tick();
        check("reset_beats_add", 32'(D_Q), 32'h1020);
        RESET = 1'b0;
        SUBTRACT = 1'b1; tick(); SUBTRACT = 1'b0; tick();
        check("sub_sat_low", 32'(D_Q), 32'h1020);
        ADD = 1'b1; tick(); ADD = 1'b0; tick();
        check("idle_add_1120", 32'(D_Q), 32'h1120);

`ifdef BCD_TIMER_LAP_EN
        // ---- lap capture and lap display ----
        drive_idle();
        RESET = 1'b1; REVERSE = 1'b0;
        tick(); tick();
        check("lap_reset", 32'(LAP_Q), 32'h0000);
        RESET = 1'b0; START = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (D_Q == 16'h1234) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_1234", 32'(found), 32'd1);
        LAP = 1'b1; tick(); LAP = 1'b0;
        check("lap_capture", 32'(LAP_Q), 32'h1234);
        LAP_SHOW = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("lap_show_mid", 32'(D_Q), 32'h1234);
        for (int i = 0; i < 5; i++) tick();
        check("lap_show_end", 32'(D_Q), 32'h1234);
        LAP_SHOW = 1'b0;
        tick();
        check("lap_live_resume", 32'(D_Q), 32'h1237);
`endif

        // ---- error and speed rows ----
        apply_rows(8, NV - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
